// File: rtl/rob_pkg.sv
// Shared reorder-buffer definitions: op-type encodings and a control-op helper.
// Latency: none (definitions only).
// Backpressure: none.
package rob_pkg;

  localparam logic [1:0] OP_REGISTER = 2'd0;
  localparam logic [1:0] OP_BRANCH   = 2'd1;
  localparam logic [1:0] OP_JALR     = 2'd2;
  localparam logic [1:0] OP_STORE    = 2'd3;

  // Control ops close the commit window: nothing younger may retire alongside them.
  function automatic logic is_control(input logic [1:0] op);
    return (op == OP_BRANCH) || (op == OP_JALR);
  endfunction

endpackage

// File: rtl/rob_commit_select.sv
// Picks up to COMMIT_W in-order retirements starting at head.
// Latency: purely combinational.
// Backpressure: the window stops at the first unready entry or just after a control op.
module rob_commit_select
  import rob_pkg::*;
#(
  parameter int ROB_WIDTH = 3,
  parameter int COMMIT_W  = 2
) (
  input  logic [ROB_WIDTH-1:0]        head,
  input  logic [(1<<ROB_WIDTH)-1:0]   busy,
  input  logic [(1<<ROB_WIDTH)-1:0]   ready,
  input  logic [2*(1<<ROB_WIDTH)-1:0] optype,
  output logic [COMMIT_W-1:0]         retire_mask,
  output logic [2:0]                  retire_cnt
);

  logic                 open;
  logic [ROB_WIDTH-1:0] idx;

  // Walk slots oldest-first; a slot retires only if every earlier slot did and no control op preceded it.
  always_comb begin
    retire_mask = '0;
    retire_cnt  = '0;
    open        = 1'b1;
    idx         = head;
    for (int k = 0; k < COMMIT_W; k++) begin
      idx = head + ROB_WIDTH'(k);
      if (open && busy[idx] && ready[idx]) begin
        retire_mask[k] = 1'b1;
        retire_cnt     = retire_cnt + 3'd1;
        if (is_control(optype[2*idx +: 2])) begin
          open = 1'b0;
        end
      end else begin
        open = 1'b0;
      end
    end
  end

endmodule

// File: rtl/rob_multi_commit.sv
// Reorder buffer with CDB_PORTS result ports and up to COMMIT_W in-order retirements per cycle.
// Latency: a result is retired (outputs registered) the cycle after its entry at the head becomes ready.
// Backpressure: alloc dropped while full; rdy_in low freezes all state. Optional ROB_PERF_EN adds perf counters.
module rob_multi_commit
  import rob_pkg::*;
#(
  parameter int ROB_WIDTH = 3,
  parameter int CDB_PORTS = 2,
  parameter int COMMIT_W  = 2,
  parameter int XLEN      = 32
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          rdy_in,
  input  logic                          alloc_en,
  input  logic [1:0]                    alloc_optype,
  input  logic [4:0]                    alloc_rd,
  input  logic [XLEN-1:0]               alloc_pc,
  input  logic [XLEN-1:0]               alloc_alt_pc,
  input  logic                          alloc_pred,
  input  logic                          alloc_ready,
  input  logic [XLEN-1:0]               alloc_data,
  output logic [ROB_WIDTH-1:0]          alloc_index,
  output logic                          full,
  output logic                          empty,
  output logic [ROB_WIDTH:0]            count,
  input  logic [CDB_PORTS-1:0]          cdb_en,
  input  logic [CDB_PORTS*ROB_WIDTH-1:0] cdb_index,
  input  logic [CDB_PORTS*XLEN-1:0]     cdb_data,
  output logic [COMMIT_W-1:0]           rf_wr_en,
  output logic [COMMIT_W*5-1:0]         rf_wr_reg,
  output logic [COMMIT_W*ROB_WIDTH-1:0] rf_wr_index,
  output logic [COMMIT_W*XLEN-1:0]      rf_wr_data,
  output logic                          jalr_en,
  output logic [XLEN-1:0]               jalr_target,
  output logic                          redirect_en,
  output logic [XLEN-1:0]               redirect_pc,
  output logic                          bp_en,
  output logic [XLEN-1:0]               bp_pc,
  output logic                          bp_taken,
  output logic                          flush_out
`ifdef ROB_PERF_EN
  ,
  output logic [31:0]                   perf_retired,
  output logic [31:0]                   perf_mispredict
`endif
);

  localparam int DEPTH = 1 << ROB_WIDTH;

  logic [ROB_WIDTH-1:0] head, tail;
  logic [DEPTH-1:0]     busy, ready;
  logic [2*DEPTH-1:0]   op_q;
  logic [DEPTH-1:0]     pred_q;
  logic [4:0]           rd_q   [DEPTH];
  logic [XLEN-1:0]      pc_q   [DEPTH];
  logic [XLEN-1:0]      alt_q  [DEPTH];
  logic [XLEN-1:0]      data_q [DEPTH];

  logic [COMMIT_W-1:0]  retire_mask;
  logic [2:0]           retire_cnt;
  logic                 accept;
  logic [ROB_WIDTH-1:0] slot_idx [COMMIT_W];

  assign alloc_index = tail;
  assign full        = (count == (ROB_WIDTH+1)'(DEPTH));
  assign empty       = (count == '0);
  assign accept      = alloc_en && !full;

  for (genvar k = 0; k < COMMIT_W; k++) begin : g_slot
    assign slot_idx[k] = head + ROB_WIDTH'(k);
  end

  rob_commit_select #(
    .ROB_WIDTH (ROB_WIDTH),
    .COMMIT_W  (COMMIT_W)
  ) u_select (
    .head        (head),
    .busy        (busy),
    .ready       (ready),
    .optype      (op_q),
    .retire_mask (retire_mask),
    .retire_cnt  (retire_cnt)
  );

  // Control state and registered commit outputs; CDB marks before retire-clears so a retiring entry ends idle.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      busy        <= '0;
      ready       <= '0;
      rf_wr_en    <= '0;
      rf_wr_reg   <= '0;
      rf_wr_index <= '0;
      rf_wr_data  <= '0;
      jalr_en     <= 1'b0;
      jalr_target <= '0;
      redirect_en <= 1'b0;
      redirect_pc <= '0;
      bp_en       <= 1'b0;
      bp_pc       <= '0;
      bp_taken    <= 1'b0;
      flush_out   <= 1'b0;
    end else if (rdy_in) begin
      rf_wr_en    <= '0;
      jalr_en     <= 1'b0;
      redirect_en <= 1'b0;
      bp_en       <= 1'b0;
      flush_out   <= 1'b0;
      if (flush_out) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
        busy  <= '0;
        ready <= '0;
      end else begin
        for (int p = 0; p < CDB_PORTS; p++) begin
          if (cdb_en[p] && busy[cdb_index[p*ROB_WIDTH +: ROB_WIDTH]]) begin
            ready[cdb_index[p*ROB_WIDTH +: ROB_WIDTH]] <= 1'b1;
          end
        end
        for (int k = 0; k < COMMIT_W; k++) begin
          if (retire_mask[k]) begin
            busy[slot_idx[k]]  <= 1'b0;
            ready[slot_idx[k]] <= 1'b0;
            case (op_q[2*slot_idx[k] +: 2])
              OP_REGISTER: begin
                rf_wr_en[k]                       <= (rd_q[slot_idx[k]] != 5'd0);
                rf_wr_reg[k*5 +: 5]               <= rd_q[slot_idx[k]];
                rf_wr_index[k*ROB_WIDTH +: ROB_WIDTH] <= slot_idx[k];
                rf_wr_data[k*XLEN +: XLEN]        <= data_q[slot_idx[k]];
              end
              OP_JALR: begin
                rf_wr_en[k]                       <= (rd_q[slot_idx[k]] != 5'd0);
                rf_wr_reg[k*5 +: 5]               <= rd_q[slot_idx[k]];
                rf_wr_index[k*ROB_WIDTH +: ROB_WIDTH] <= slot_idx[k];
                rf_wr_data[k*XLEN +: XLEN]        <= pc_q[slot_idx[k]] + XLEN'(4);
                jalr_en                           <= 1'b1;
                jalr_target                       <= data_q[slot_idx[k]];
              end
              OP_BRANCH: begin
                bp_en    <= 1'b1;
                bp_pc    <= pc_q[slot_idx[k]];
                bp_taken <= data_q[slot_idx[k]][0];
                if (data_q[slot_idx[k]][0] != pred_q[slot_idx[k]]) begin
                  redirect_en <= 1'b1;
                  redirect_pc <= alt_q[slot_idx[k]];
                  flush_out   <= 1'b1;
                end
              end
              default: ;
            endcase
          end
        end
        if (accept) begin
          busy[tail]  <= 1'b1;
          ready[tail] <= alloc_ready;
          tail        <= tail + 1'b1;
        end
        head  <= head + ROB_WIDTH'(retire_cnt);
        count <= count + (ROB_WIDTH+1)'(accept) - (ROB_WIDTH+1)'(retire_cnt);
      end
    end
  end

  // Entry payload: captured at allocation, data overwritten by CDB results for busy entries.
  always_ff @(posedge clk_in) begin
    if (rdy_in && !flush_out) begin
      for (int p = 0; p < CDB_PORTS; p++) begin
        if (cdb_en[p] && busy[cdb_index[p*ROB_WIDTH +: ROB_WIDTH]]) begin
          data_q[cdb_index[p*ROB_WIDTH +: ROB_WIDTH]] <= cdb_data[p*XLEN +: XLEN];
        end
      end
      if (accept) begin
        op_q[2*tail +: 2] <= alloc_optype;
        rd_q[tail]        <= alloc_rd;
        pc_q[tail]        <= alloc_pc;
        alt_q[tail]       <= alloc_alt_pc;
        pred_q[tail]      <= alloc_pred;
        data_q[tail]      <= alloc_data;
      end
    end
  end

`ifdef ROB_PERF_EN
  logic mispredict;

  // A mispredicted branch is being retired this cycle.
  always_comb begin
    mispredict = 1'b0;
    for (int k = 0; k < COMMIT_W; k++) begin
      if (retire_mask[k] && (op_q[2*slot_idx[k] +: 2] == OP_BRANCH) &&
          (data_q[slot_idx[k]][0] != pred_q[slot_idx[k]])) begin
        mispredict = 1'b1;
      end
    end
  end

  // Saturating perf counters; only reset clears them, a flush does not.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      perf_retired    <= '0;
      perf_mispredict <= '0;
    end else if (rdy_in && !flush_out) begin
      if (perf_retired > (32'hFFFF_FFFF - 32'(retire_cnt))) begin
        perf_retired <= 32'hFFFF_FFFF;
      end else begin
        perf_retired <= perf_retired + 32'(retire_cnt);
      end
      if (mispredict && (perf_mispredict != 32'hFFFF_FFFF)) begin
        perf_mispredict <= perf_mispredict + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_rob_multi_commit.sv
// Bench for rob_multi_commit: queue-level reference model plus directed scenarios with literal expectations.
// Latency: model outputs update at each rising edge and are compared on the falling edge.
// Backpressure: stimulus exercises full, freeze (rdy_in low) and flush.
module tb_rob_multi_commit;

  localparam int RW    = 3;
  localparam int DEPTH = 8;
  localparam int NP    = 2;
  localparam int CW    = 2;
  localparam logic [1:0] T_REG = 2'd0, T_BR = 2'd1, T_JR = 2'd2, T_ST = 2'd3;

  logic            clk_in = 1'b0;
  logic            rst_in, rdy_in;
  logic            alloc_en, alloc_pred, alloc_ready;
  logic [1:0]      alloc_optype;
  logic [4:0]      alloc_rd;
  logic [31:0]     alloc_pc, alloc_alt_pc, alloc_data;
  logic [RW-1:0]   alloc_index;
  logic            full, empty;
  logic [RW:0]     count;
  logic [NP-1:0]   cdb_en;
  logic [NP*RW-1:0] cdb_index;
  logic [NP*32-1:0] cdb_data;
  logic [CW-1:0]   rf_wr_en;
  logic [CW*5-1:0] rf_wr_reg;
  logic [CW*RW-1:0] rf_wr_index;
  logic [CW*32-1:0] rf_wr_data;
  logic            jalr_en, redirect_en, bp_en, bp_taken, flush_out;
  logic [31:0]     jalr_target, redirect_pc, bp_pc;
`ifdef ROB_PERF_EN
  logic [31:0]     perf_retired, perf_mispredict;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk_in = ~clk_in;

  rob_multi_commit dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .alloc_en(alloc_en), .alloc_optype(alloc_optype), .alloc_rd(alloc_rd),
    .alloc_pc(alloc_pc), .alloc_alt_pc(alloc_alt_pc), .alloc_pred(alloc_pred),
    .alloc_ready(alloc_ready), .alloc_data(alloc_data), .alloc_index(alloc_index),
    .full(full), .empty(empty), .count(count),
    .cdb_en(cdb_en), .cdb_index(cdb_index), .cdb_data(cdb_data),
    .rf_wr_en(rf_wr_en), .rf_wr_reg(rf_wr_reg), .rf_wr_index(rf_wr_index), .rf_wr_data(rf_wr_data),
    .jalr_en(jalr_en), .jalr_target(jalr_target),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .bp_en(bp_en), .bp_pc(bp_pc), .bp_taken(bp_taken), .flush_out(flush_out)
`ifdef ROB_PERF_EN
    , .perf_retired(perf_retired), .perf_mispredict(perf_mispredict)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model: ordered queue of in-flight ops ----------------
  typedef struct {
    logic [1:0]  op;
    logic [4:0]  rd;
    logic [31:0] pc, alt, data;
    logic        pred, rdy;
    int          tag;
  } ment_t;

  ment_t       mq[$];
  int          m_tail = 0;
  logic        m_flush = 1'b0;
  logic [CW-1:0] m_rf_en = '0;
  logic [4:0]  m_rf_reg [CW];
  logic [RW-1:0] m_rf_idx [CW];
  logic [31:0] m_rf_data [CW];
  logic        m_jalr_en = 1'b0, m_red_en = 1'b0, m_bp_en = 1'b0, m_bp_taken = 1'b0;
  logic [31:0] m_jalr_tgt = '0, m_red_pc = '0, m_bp_pc = '0;

  task automatic m_step();
    bit    full_pre, stop;
    int    n;
    ment_t e, ne;
    full_pre  = (mq.size() == DEPTH);
    m_rf_en   = '0;
    m_jalr_en = 1'b0;
    m_red_en  = 1'b0;
    m_bp_en   = 1'b0;
    if (m_flush) begin
      mq.delete();
      m_tail  = 0;
      m_flush = 1'b0;
      return;
    end
    n = 0;
    stop = 1'b0;
    for (int k = 0; k < CW; k++) begin
      if (!stop && k < mq.size() && mq[k].rdy) begin
        e = mq[k];
        n++;
        if (e.op == T_REG || e.op == T_JR) begin
          m_rf_en[k]   = (e.rd != 5'd0);
          m_rf_reg[k]  = e.rd;
          m_rf_idx[k]  = RW'(e.tag);
          m_rf_data[k] = (e.op == T_JR) ? e.pc + 32'd4 : e.data;
        end
        if (e.op == T_JR) begin
          m_jalr_en  = 1'b1;
          m_jalr_tgt = e.data;
        end
        if (e.op == T_BR) begin
          m_bp_en    = 1'b1;
          m_bp_pc    = e.pc;
          m_bp_taken = e.data[0];
          if (e.data[0] != e.pred) begin
            m_red_en = 1'b1;
            m_red_pc = e.alt;
            m_flush  = 1'b1;
          end
        end
        if (e.op == T_BR || e.op == T_JR) stop = 1'b1;
      end else begin
        stop = 1'b1;
      end
    end
    for (int j = 0; j < n; j++) void'(mq.pop_front());
    for (int p = 0; p < NP; p++) begin
      if (cdb_en[p]) begin
        foreach (mq[i]) begin
          if (mq[i].tag == int'(cdb_index[p*RW +: RW])) begin
            mq[i].rdy  = 1'b1;
            mq[i].data = cdb_data[p*32 +: 32];
          end
        end
      end
    end
    if (alloc_en && !full_pre) begin
      ne.op = alloc_optype; ne.rd = alloc_rd; ne.pc = alloc_pc; ne.alt = alloc_alt_pc;
      ne.data = alloc_data; ne.pred = alloc_pred; ne.rdy = alloc_ready; ne.tag = m_tail;
      mq.push_back(ne);
      m_tail = (m_tail + 1) % DEPTH;
    end
  endtask

  always @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      mq.delete();
      m_tail = 0; m_flush = 1'b0; m_rf_en = '0;
      m_jalr_en = 1'b0; m_red_en = 1'b0; m_bp_en = 1'b0; m_bp_taken = 1'b0;
      m_jalr_tgt = '0; m_red_pc = '0; m_bp_pc = '0;
    end else if (rdy_in) begin
      m_step();
    end
  end

  // Every cycle: DUT outputs against the model.
  always @(negedge clk_in) begin
    chk("count", 64'(count), 64'(mq.size()));
    chk("empty", 64'(empty), 64'(mq.size() == 0));
    chk("full", 64'(full), 64'(mq.size() == DEPTH));
    chk("alloc_index", 64'(alloc_index), 64'(m_tail));
    chk("rf_wr_en", 64'(rf_wr_en), 64'(m_rf_en));
    for (int k = 0; k < CW; k++) begin
      if (m_rf_en[k]) begin
        chk("rf_wr_reg", 64'(rf_wr_reg[k*5 +: 5]), 64'(m_rf_reg[k]));
        chk("rf_wr_index", 64'(rf_wr_index[k*RW +: RW]), 64'(m_rf_idx[k]));
        chk("rf_wr_data", 64'(rf_wr_data[k*32 +: 32]), 64'(m_rf_data[k]));
      end
    end
    chk("jalr_en", 64'(jalr_en), 64'(m_jalr_en));
    if (m_jalr_en) chk("jalr_target", 64'(jalr_target), 64'(m_jalr_tgt));
    chk("redirect_en", 64'(redirect_en), 64'(m_red_en));
    if (m_red_en) chk("redirect_pc", 64'(redirect_pc), 64'(m_red_pc));
    chk("bp_en", 64'(bp_en), 64'(m_bp_en));
    if (m_bp_en) begin
      chk("bp_pc", 64'(bp_pc), 64'(m_bp_pc));
      chk("bp_taken", 64'(bp_taken), 64'(m_bp_taken));
    end
    chk("flush_out", 64'(flush_out), 64'(m_flush));
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic alloc(input logic [1:0] op, input logic [4:0] rd, input logic [31:0] pc,
                       input logic [31:0] alt, input logic pred, input logic rdy, input logic [31:0] data);
    alloc_en = 1'b1; alloc_optype = op; alloc_rd = rd; alloc_pc = pc; alloc_alt_pc = alt;
    alloc_pred = pred; alloc_ready = rdy; alloc_data = data;
    step();
    alloc_en = 1'b0;
  endtask

  task automatic cdb2(input logic [1:0] en, input logic [RW-1:0] i0, input logic [31:0] d0,
                      input logic [RW-1:0] i1, input logic [31:0] d1);
    cdb_en = en; cdb_index = {i1, i0}; cdb_data = {d1, d0};
  endtask

  initial begin
    rst_in = 1'b0; rdy_in = 1'b1;
    alloc_en = 1'b0; alloc_optype = '0; alloc_rd = '0; alloc_pc = '0; alloc_alt_pc = '0;
    alloc_pred = 1'b0; alloc_ready = 1'b0; alloc_data = '0;
    cdb_en = '0; cdb_index = '0; cdb_data = '0;
    #1 rst_in = 1'b1;
    @(negedge clk_in);
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_empty", 64'(empty), 64'(1));
    chk("rst_rf_wr_en", 64'(rf_wr_en), 64'(0));
    chk("rst_flush", 64'(flush_out), 64'(0));
    step(); step();
    rst_in = 1'b0;

    // Fill to full, 9th alloc dropped, then drain in pairs.
    for (int i = 0; i < 9; i++) alloc(T_REG, 5'(i + 1), 32'h1000 + 32'(4 * i), 32'h0, 1'b0, 1'b0, 32'h0);
    chk("fill_full", 64'(full), 64'(1));
    chk("fill_count", 64'(count), 64'(8));
    chk("fill_tail", 64'(alloc_index), 64'(0));
    cdb2(2'b11, 3'd0, 32'h100, 3'd1, 32'h101);
    step();
    for (int i = 0; i < 4; i++) begin
      if (i < 3) cdb2(2'b11, 3'(2 * i + 2), 32'h100 + 32'(2 * i + 2), 3'(2 * i + 3), 32'h100 + 32'(2 * i + 3));
      else cdb_en = '0;
      step();
      chk("drain_en", 64'(rf_wr_en), 64'(2'b11));
      chk("drain_pair", 64'(rf_wr_reg), 64'({5'(2 * i + 2), 5'(2 * i + 1)}));
      if (i == 0) chk("drain_data", 64'(rf_wr_data), 64'h0000_0101_0000_0100);
    end
    chk("drain_empty", 64'(empty), 64'(1));

    // Dual CDB out of order: index 2 must wait for index 1.
    for (int i = 0; i < 3; i++) alloc(T_REG, 5'(i + 3), 32'h2000, 32'h0, 1'b0, 1'b0, 32'h0);
    cdb2(2'b11, 3'd2, 32'hAAAA, 3'd0, 32'hBBBB);
    step(); cdb_en = '0; step();
    chk("dual_en", 64'(rf_wr_en), 64'(2'b01));
    chk("dual_reg", 64'(rf_wr_reg[4:0]), 64'(3));
    chk("dual_data", 64'(rf_wr_data[31:0]), 64'hBBBB);
    chk("dual_count", 64'(count), 64'(2));
    cdb2(2'b01, 3'd1, 32'hCCCC, 3'd0, 32'h0);
    step(); cdb_en = '0; step();
    chk("dual2_en", 64'(rf_wr_en), 64'(2'b11));
    chk("dual2_reg", 64'(rf_wr_reg), 64'({5'd5, 5'd4}));
    chk("dual2_data", 64'(rf_wr_data), 64'h0000_AAAA_0000_CCCC);

    // Mispredicted branch with a ready younger entry behind it.
    alloc(T_BR, 5'd0, 32'h80, 32'h100, 1'b1, 1'b0, 32'h0);
    alloc(T_REG, 5'd6, 32'h84, 32'h0, 1'b0, 1'b1, 32'h66);
    cdb2(2'b01, 3'd3, 32'h0, 3'd0, 32'h0);
    step(); cdb_en = '0; step();
    chk("mp_bp_en", 64'(bp_en), 64'(1));
    chk("mp_bp_taken", 64'(bp_taken), 64'(0));
    chk("mp_bp_pc", 64'(bp_pc), 64'h80);
    chk("mp_redirect_pc", 64'(redirect_pc), 64'h100);
    chk("mp_flush", 64'(flush_out), 64'(1));
    chk("mp_no_rf", 64'(rf_wr_en), 64'(0));
    step();
    chk("mp_count", 64'(count), 64'(0));
    chk("mp_flush_drop", 64'(flush_out), 64'(0));
    chk("mp_no_rf2", 64'(rf_wr_en), 64'(0));
    step();
    chk("mp_no_rf3", 64'(rf_wr_en), 64'(0));

    // JALR then a ready REGISTER behind it.
    alloc(T_JR, 5'd1, 32'h40, 32'h0, 1'b0, 1'b0, 32'h0);
    alloc(T_REG, 5'd2, 32'h44, 32'h0, 1'b0, 1'b1, 32'h22);
    cdb2(2'b01, 3'd0, 32'h200, 3'd0, 32'h0);
    step(); cdb_en = '0; step();
    chk("jalr_rf_en", 64'(rf_wr_en), 64'(2'b01));
    chk("jalr_rf_reg", 64'(rf_wr_reg[4:0]), 64'(1));
    chk("jalr_rf_data", 64'(rf_wr_data[31:0]), 64'h44);
    chk("jalr_en_lit", 64'(jalr_en), 64'(1));
    chk("jalr_tgt_lit", 64'(jalr_target), 64'h200);
    step();
    chk("jalr_next_reg", 64'(rf_wr_reg[4:0]), 64'(2));
    chk("jalr_next_data", 64'(rf_wr_data[31:0]), 64'h22);
    chk("jalr_next_idx", 64'(rf_wr_index[2:0]), 64'(1));

    // Stores advance head to 7, then a wrapped pair with rd=0 in slot 0.
    for (int i = 0; i < 5; i++) alloc(T_ST, 5'd0, 32'h3000, 32'h0, 1'b0, 1'b1, 32'h0);
    step(); step();
    chk("wrap_head7", 64'(alloc_index), 64'(7));
    alloc(T_REG, 5'd0, 32'h3100, 32'h0, 1'b0, 1'b0, 32'h0);
    alloc(T_REG, 5'd9, 32'h3104, 32'h0, 1'b0, 1'b0, 32'h0);
    cdb2(2'b11, 3'd7, 32'h77, 3'd0, 32'h99);
    step(); cdb_en = '0; step();
    chk("wrap_en", 64'(rf_wr_en), 64'(2'b10));
    chk("wrap_reg", 64'(rf_wr_reg[9:5]), 64'(9));
    chk("wrap_data", 64'(rf_wr_data[63:32]), 64'h99);
    chk("wrap_count", 64'(count), 64'(0));
    chk("wrap_tail", 64'(alloc_index), 64'(1));

    // Freeze right after a commit: outputs and state hold despite CDB and alloc activity.
    alloc(T_REG, 5'd10, 32'h4000, 32'h0, 1'b0, 1'b1, 32'h10A);
    alloc(T_REG, 5'd11, 32'h4004, 32'h0, 1'b0, 1'b0, 32'h0);
    rdy_in = 1'b0;
    cdb2(2'b01, 3'd2, 32'h10B, 3'd0, 32'h0);
    alloc_en = 1'b1; alloc_rd = 5'd12; alloc_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("frz_count", 64'(count), 64'(1));
      chk("frz_rf_en", 64'(rf_wr_en), 64'(2'b01));
      chk("frz_rf_reg", 64'(rf_wr_reg[4:0]), 64'(10));
      chk("frz_tail", 64'(alloc_index), 64'(3));
    end
    alloc_en = 1'b0;
    rdy_in = 1'b1;
    step(); cdb_en = '0; step();
    chk("thaw_rf_reg", 64'(rf_wr_reg[4:0]), 64'(11));
    chk("thaw_rf_data", 64'(rf_wr_data[31:0]), 64'h10B);
    chk("thaw_count", 64'(count), 64'(0));

    step(); step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
